// File: rtl/genesis_pad_scanner.sv
// Genesis DB-9 pad scanner: drives select, samples both mux phases, and commits
// a frame-coherent active-high button word with a pad-present flag.
module genesis_pad_scanner #(
    parameter int unsigned PHASE_CYCLES  = 500,
    parameter int unsigned SETTLE_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_z,
    input  logic       down_y,
    input  logic       left_x,
    input  logic       right,
    input  logic       a_b,
    input  logic       start_c,
    output logic       select_out,
    output logic [7:0] buttons,
    output logic       pad_present,
    output logic       frame_valid,
    output logic       changed
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PIN_W  = 6;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);

    // Pin vector layout after synchronization
    localparam int unsigned P_UP    = 0;
    localparam int unsigned P_DOWN  = 1;
    localparam int unsigned P_LEFT  = 2;
    localparam int unsigned P_RIGHT = 3;
    localparam int unsigned P_AB    = 4;
    localparam int unsigned P_SC    = 5;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t             r_state;
    phase_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PIN_W-1:0]   r_sync1;
    logic [PIN_W-1:0]   r_sync2;
    logic               r_low_a;
    logic               r_low_start;
    logic               r_low_sig;
    logic               r_have_low;
    logic [7:0]         r_buttons;
    logic               r_pad_present;
    logic               r_frame_valid;
    logic               r_changed;
    logic               w_low_sample;
    logic               w_commit;
    logic [7:0]         w_btn_new;

    // Two-flop synchronizer on the raw pins, idle-high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {start_c, a_b, right, left_x, down_y, up_z};
            r_sync2 <= r_sync1;
        end
    end

    // Phase state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= PH_HIGH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next phase, counter wrap and sample strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_low_sample = 1'b0;
        w_commit     = 1'b0;
        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == PH_HIGH) ? PH_LOW : PH_HIGH;
        end
        case (r_state)
            PH_LOW:  w_low_sample = (r_cnt == CNT_SETTLE);
            PH_HIGH: w_commit     = (r_cnt == CNT_SETTLE) && r_have_low;
            default: ;
        endcase
    end

    // Bit order {start, C, B, A, right, left, down, up}; zero without a signature
    always_comb begin
        w_btn_new = '0;
        if (r_low_sig) begin
            w_btn_new = {r_low_start, ~r_sync2[P_SC], ~r_sync2[P_AB], r_low_a,
                         ~r_sync2[P_RIGHT], ~r_sync2[P_LEFT],
                         ~r_sync2[P_DOWN], ~r_sync2[P_UP]};
        end
    end

    // Low-phase capture and frame commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_low_a       <= 1'b0;
            r_low_start   <= 1'b0;
            r_low_sig     <= 1'b0;
            r_have_low    <= 1'b0;
            r_buttons     <= '0;
            r_pad_present <= 1'b0;
            r_frame_valid <= 1'b0;
            r_changed     <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            r_changed     <= 1'b0;
            if (w_low_sample) begin
                r_low_a     <= ~r_sync2[P_AB];
                r_low_start <= ~r_sync2[P_SC];
                r_low_sig   <= ~r_sync2[P_LEFT] & ~r_sync2[P_RIGHT];
                r_have_low  <= 1'b1;
            end
            if (w_commit) begin
                r_buttons     <= w_btn_new;
                r_pad_present <= r_low_sig;
                r_changed     <= (w_btn_new != r_buttons);
                r_have_low    <= 1'b0;
            end
        end
    end

    assign select_out  = (r_state == PH_HIGH);
    assign buttons     = r_buttons;
    assign pad_present = r_pad_present;
    assign frame_valid = r_frame_valid;
    assign changed     = r_changed;

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Bench for genesis_pad_scanner: behavioural pad + frame model checked every
// cycle, plus directed literal expectations on key frames.
module tb_genesis_pad_scanner;

    localparam int P = 8;
    localparam int S = 3;
    localparam int FIRST_FV = 2 * P + S + 1;
    localparam int PERIOD   = 2 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_z, down_y, left_x, right, a_b, start_c;
    logic       select_out;
    logic [7:0] buttons;
    logic       pad_present, frame_valid, changed;

    // Pad model state: pressed buttons in output bit order, signature drive, glitch
    logic [7:0] p_btn = 8'h00;
    logic       sig_on = 1'b0;
    logic       glitch = 1'b0;

    int errors = 0;
    int checks = 0;
    int n = 0;

    logic [5:0] hist [32];
    logic [7:0] m_btn = 8'h00;
    logic       m_pad = 1'b0;

    genesis_pad_scanner #(.PHASE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .up_z(up_z), .down_y(down_y), .left_x(left_x), .right(right),
        .a_b(a_b), .start_c(start_c),
        .select_out(select_out), .buttons(buttons), .pad_present(pad_present),
        .frame_valid(frame_valid), .changed(changed)
    );

    always #5 clk = ~clk;

    // 3-button Genesis pad: select high shows d-pad/B/C, select low shows A/start and the signature
    assign up_z    = ~p_btn[0];
    assign down_y  = ~p_btn[1];
    assign left_x  = select_out ? ~p_btn[2] : ~sig_on;
    assign right   = select_out ? ~p_btn[3] : ~sig_on;
    assign a_b     = (select_out ? ~p_btn[5] : ~p_btn[4]) & ~glitch;
    assign start_c = select_out ? ~p_btn[6] : ~p_btn[7];

    wire [5:0] w_pins = {start_c, a_b, right, left_x, down_y, up_z};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    // Per-cycle model: select from elapsed time, commits on a fixed schedule, decode from pin history
    always @(negedge clk) begin
        logic [5:0] lo, hi;
        logic [7:0] nb;
        logic       sig, commit, exp_ch;
        if (!reset) begin
            m_btn = 8'h00;
            m_pad = 1'b0;
            chk("rst_select", int'(select_out), 1);
            chk("rst_buttons", int'(buttons), 0);
            chk("rst_pad", int'(pad_present), 0);
            chk("rst_fv", int'(frame_valid), 0);
            chk("rst_changed", int'(changed), 0);
            hist[1] = w_pins;
        end else begin
            commit = (n >= FIRST_FV) && (((n - FIRST_FV) % PERIOD) == 0);
            exp_ch = 1'b0;
            if (commit) begin
                lo  = hist[(n - P - 2) % 32];
                hi  = hist[(n - 2) % 32];
                sig = (lo[2] == 1'b0) && (lo[3] == 1'b0);
                nb  = sig ? {~lo[5], ~hi[5], ~hi[4], ~lo[4], ~hi[3], ~hi[2], ~hi[1], ~hi[0]} : 8'h00;
                exp_ch = (nb != m_btn);
                m_btn  = nb;
                m_pad  = sig;
            end
            chk("select", int'(select_out), int'(((n / P) % 2) == 0));
            chk("frame_valid", int'(frame_valid), int'(commit));
            chk("buttons", int'(buttons), int'(m_btn));
            chk("pad_present", int'(pad_present), int'(m_pad));
            chk("changed", int'(changed), int'(exp_ch));
            hist[(n + 1) % 32] = w_pins;
        end
    end

    task automatic wait_fv(output int at_n);
        at_n = -1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                at_n = n;
                return;
            end
        end
        chk("fv_timeout", 0, 1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int t, t2;
        repeat (3) @(negedge clk);
        release_reset();

        // Idle, no pad
        wait_fv(t);
        chk("first_fv_cycle", t, 20);
        chk("idle_buttons", int'(buttons), 0);
        chk("idle_pad", int'(pad_present), 0);
        wait_fv(t2);
        chk("fv_period", t2 - t, 16);

        // Pad present, nothing pressed
        @(posedge clk); #1 sig_on = 1'b1;
        wait_fv(t);
        chk("present_pad", int'(pad_present), 1);
        chk("present_buttons", int'(buttons), 8'h00);
        chk("present_changed", int'(changed), 0);

        // A + C + up
        @(posedge clk); #1 p_btn = 8'h51;
        wait_fv(t);
        chk("acu_buttons", int'(buttons), 8'h51);
        chk("acu_changed", int'(changed), 1);
        wait_fv(t);
        chk("acu_hold_buttons", int'(buttons), 8'h51);
        chk("acu_hold_changed", int'(changed), 0);

        // C + left + up
        @(posedge clk); #1 p_btn = 8'h45;
        wait_fv(t);
        chk("clu_buttons", int'(buttons), 8'h45);
        chk("clu_changed", int'(changed), 1);

        // Signature lost
        @(posedge clk); #1 sig_on = 1'b0;
        wait_fv(t);
        chk("lost_pad", int'(pad_present), 0);
        chk("lost_buttons", int'(buttons), 8'h00);
        chk("lost_changed", int'(changed), 1);

        // Start + right + down, then reset at PH_LOW cnt=5
        @(posedge clk); #1 begin sig_on = 1'b1; p_btn = 8'h8A; end
        wait_fv(t);
        chk("srd_buttons", int'(buttons), 8'h8A);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_select_low", int'(select_out), 0);
        reset = 1'b0;
        #1;
        chk("async_select", int'(select_out), 1);
        chk("async_buttons", int'(buttons), 0);
        chk("async_pad", int'(pad_present), 0);
        chk("async_fv", int'(frame_valid), 0);
        repeat (2) @(negedge clk);
        release_reset();
        wait_fv(t);
        chk("post_rst_fv_cycle", t, 20);
        chk("post_rst_buttons", int'(buttons), 8'h8A);
        chk("post_rst_changed", int'(changed), 1);
        wait_fv(t);

        // One-cycle a_b low pulse captured at cnt=5, away from both sample points
        @(posedge clk); #1 glitch = 1'b1;
        @(posedge clk); #1 glitch = 1'b0;
        wait_fv(t);
        chk("glitch_buttons", int'(buttons), 8'h8A);
        chk("glitch_changed", int'(changed), 0);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
